mem_stage: RTL and testbench

Memory-access stage of the pipelined MIPS core, directly downstream of the execute-stage ALU. It consumes the ALU result from the EX/MEM register as a word address and performs loads and stores over a ready-handshaked data-memory port. It stalls the upstream pipeline while an access is outstanding and contains the MEM/WB pipeline register. Misaligned addresses and memory timeouts are converted into one-cycle error pulses and a killed register write.

---
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the pipelined MIPS core. Takes the EX/MEM register
// contents, performs lw/sw over a ready-handshaked data-memory port, stalls
// the upstream pipeline while an access is outstanding and holds the MEM/WB
// pipeline register. Misaligned addresses and memory timeouts retire as
// one-cycle error pulses with the register write killed.
//
// Parameters:
//   TIMEOUT        max cycles spent in ACCESS waiting for dmem_ready (1..255)
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_*           EX/MEM register fields (valid, ALU result, store data,
//                  mem_read, mem_write, reg_write, destination register)
//   stall          combinational hold request for EX/MEM and earlier stages
//   dmem_*         data-memory port (req registered, others follow inputs)
//   wb_*           MEM/WB register fields
//   addr_err       one-cycle pulse: misaligned memory op retired
//   bus_err        one-cycle pulse: memory access timed out
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_write_data,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_reg_write,
    input  logic [4:0]  in_write_reg,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [31:0] wb_read_data,
    output logic        wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic [4:0]  wb_write_reg,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Wait-counter value on the last ACCESS cycle before giving up.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;

    logic        mem_op;
    logic        aligned;
    logic        in_access;
    logic        at_limit;
    logic        mem_ready;
    logic        mem_timeout;
    logic        mem_done;
    logic        is_load;

    logic        wb_valid_d;
    logic [31:0] wb_result_d;
    logic [31:0] wb_read_data_d;
    logic        wb_mem_to_reg_d;
    logic        wb_reg_write_d;
    logic [4:0]  wb_write_reg_d;
    logic        addr_err_d;
    logic        bus_err_d;

    assign mem_op      = in_valid & (in_mem_read | in_mem_write);
    assign aligned     = (in_alu_result[1:0] == 2'b00);
    assign in_access   = (state == ACCESS);
    assign at_limit    = (wait_cnt == LAST_WAIT);
    // Completion takes priority over the timeout when both land together.
    assign mem_ready   = in_access & dmem_ready;
    assign mem_timeout = in_access & ~dmem_ready & at_limit;
    assign mem_done    = mem_ready | mem_timeout;
    // A simultaneous read+write request is treated as a store.
    assign is_load     = in_mem_read & ~in_mem_write;

    // Misaligned ops never stall: they retire straight away with addr_err.
    assign stall      = mem_op & aligned & ~mem_done;

    // Address and data follow the EX/MEM register, which stall keeps stable.
    assign dmem_we    = in_mem_write;
    assign dmem_addr  = in_alu_result;
    assign dmem_wdata = in_write_data;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (mem_op && aligned) state_next = ACCESS;
            ACCESS:  if (mem_done)          state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // MEM/WB next value. A stalled cycle loads a bubble; data fields hold.
    always_comb begin
        wb_valid_d      = 1'b0;
        wb_result_d     = wb_result;
        wb_read_data_d  = wb_read_data;
        wb_mem_to_reg_d = 1'b0;
        wb_reg_write_d  = 1'b0;
        wb_write_reg_d  = wb_write_reg;
        addr_err_d      = 1'b0;
        bus_err_d       = 1'b0;
        if (!stall) begin
            wb_valid_d     = in_valid;
            wb_result_d    = in_alu_result;
            wb_write_reg_d = in_write_reg;
            wb_read_data_d = '0;
            if (mem_op) begin
                // Unstalled aligned op here means the access just finished.
                if (!aligned) begin
                    addr_err_d = 1'b1;
                end else if (mem_timeout) begin
                    bus_err_d = 1'b1;
                end else if (is_load) begin
                    wb_read_data_d  = dmem_rdata;
                    wb_mem_to_reg_d = 1'b1;
                    wb_reg_write_d  = in_reg_write;
                end
            end else begin
                wb_reg_write_d = in_reg_write & in_valid;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            dmem_req      <= 1'b0;
            wb_valid      <= 1'b0;
            wb_result     <= '0;
            wb_read_data  <= '0;
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= '0;
            addr_err      <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            state    <= state_next;
            // Request is a registered copy of the state: high exactly in ACCESS.
            dmem_req <= (state_next == ACCESS);
            // Staying in ACCESS means no ready and limit not reached; any
            // other transition (entry or exit) restarts the count at zero.
            if (in_access && state_next == ACCESS) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
            wb_valid      <= wb_valid_d;
            wb_result     <= wb_result_d;
            wb_read_data  <= wb_read_data_d;
            wb_mem_to_reg <= wb_mem_to_reg_d;
            wb_reg_write  <= wb_reg_write_d;
            wb_write_reg  <= wb_write_reg_d;
            addr_err      <= addr_err_d;
            bus_err       <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage (TIMEOUT=4). Each memory transaction is
// predicted from a transaction-level model: given the op kind, alignment and
// the ACCESS cycle on which memory answers, the model yields the total cycle
// count, stall/request cycle counts and the retired MEM/WB contents.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_alu_result;
    logic [31:0] in_write_data;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_reg_write;
    logic [4:0]  in_write_reg;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [31:0] wb_read_data;
    logic        wb_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic        addr_err;
    logic        bus_err;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        regw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [4:0]  wreg;
        int          ready_at;   // ACCESS cycle (1-based) on which memory answers
    } op_t;

    typedef struct {
        int   cycles;
        int   stalls;
        int   reqs;
        logic regw;
        logic m2r;
        logic chk_m2r;
        logic aerr;
        logic berr;
        logic chk_rdata;
        logic chk_result;
    } exp_t;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_alu_result(in_alu_result),
        .in_write_data(in_write_data),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_reg_write (in_reg_write),
        .in_write_reg (in_write_reg),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_result    (wb_result),
        .wb_read_data (wb_read_data),
        .wb_mem_to_reg(wb_mem_to_reg),
        .wb_reg_write (wb_reg_write),
        .wb_write_reg (wb_write_reg),
        .addr_err     (addr_err),
        .bus_err      (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transaction-level reference model.
    function automatic exp_t model(input op_t op);
        exp_t e;
        e = '{cycles: 1, stalls: 0, reqs: 0, regw: 1'b0, m2r: 1'b0, chk_m2r: 1'b1,
              aerr: 1'b0, berr: 1'b0, chk_rdata: 1'b0, chk_result: 1'b0};
        if (!(op.rd || op.wr)) begin
            e.regw       = op.regw;
            e.chk_result = 1'b1;
        end else if (op.addr[1:0] != 2'b00) begin
            e.aerr = 1'b1;
        end else if (op.ready_at <= TIMEOUT) begin
            e.cycles    = 1 + op.ready_at;
            e.stalls    = op.ready_at;
            e.reqs      = op.ready_at;
            e.m2r       = op.rd && !op.wr;
            e.regw      = op.rd && !op.wr && op.regw;
            e.chk_rdata = op.rd && !op.wr;
        end else begin
            e.cycles  = 1 + TIMEOUT;
            e.stalls  = TIMEOUT;
            e.reqs    = TIMEOUT;
            e.berr    = 1'b1;
            e.chk_m2r = 1'b0;
        end
        return e;
    endfunction

    // Drives one instruction until it leaves the stage (stall low at the
    // edge), answering the memory on the requested ACCESS cycle. Called and
    // returns at posedge+1; on return MEM/WB shows the retired instruction.
    task automatic run_op(input op_t op, output int cycles, output int stalls,
                          output int reqs, output int wes, output logic [31:0] addr_seen,
                          output logic [31:0] wdata_seen, output logic finished);
        int acc;
        acc        = 0;
        cycles     = 0;
        stalls     = 0;
        wes        = 0;
        addr_seen  = '0;
        wdata_seen = '0;
        finished   = 1'b0;
        in_valid      = 1'b1;
        in_mem_read   = op.rd;
        in_mem_write  = op.wr;
        in_reg_write  = op.regw;
        in_alu_result = op.addr;
        in_write_data = op.data;
        in_write_reg  = op.wreg;
        dmem_rdata    = op.rdata;
        dmem_ready    = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge clk);
            if (dmem_req) begin
                acc++;
                if (acc == 1) begin
                    addr_seen  = dmem_addr;
                    wdata_seen = dmem_wdata;
                end
                if (dmem_we) wes++;
            end
            dmem_ready = dmem_req && (acc == op.ready_at);
            #1;
            if (stall) stalls++;
            else       finished = 1'b1;
            cycles++;
            @(posedge clk);
            #1;
        end
        reqs         = acc;
        in_valid     = 1'b0;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({dmem_req, wb_valid, wb_reg_write, wb_mem_to_reg, addr_err, bus_err} !== 6'b0) begin
            $display("FAIL reset_ctrl: got req/valid/regw/m2r/aerr/berr=%b want 000000",
                     {dmem_req, wb_valid, wb_reg_write, wb_mem_to_reg, addr_err, bus_err});
        end else pass_cnt++;
        total_cnt++;
        if ({wb_result, wb_read_data, wb_write_reg} !== 69'b0) begin
            $display("FAIL reset_data: got result=%h rdata=%h reg=%0d want zeros",
                     wb_result, wb_read_data, wb_write_reg);
        end else pass_cnt++;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ops();
        op_t  ops[$];
        op_t  op;
        exp_t e;
        int   cycles, stalls, reqs, wes;
        logic [31:0] addr_seen, wdata_seen;
        logic finished;
        ops.push_back('{rd: 0, wr: 0, regw: 1, addr: 32'h0000_0005, data: 32'h0, rdata: 32'h0, wreg: 9, ready_at: 1});
        ops.push_back('{rd: 1, wr: 0, regw: 1, addr: 32'h0000_0010, data: 32'h0, rdata: 32'hDEAD_BEEF, wreg: 4, ready_at: 3});
        ops.push_back('{rd: 0, wr: 1, regw: 0, addr: 32'h0000_0020, data: 32'h1234_5678, rdata: 32'h0, wreg: 0, ready_at: 1});
        ops.push_back('{rd: 1, wr: 0, regw: 1, addr: 32'h0000_0013, data: 32'h0, rdata: 32'h5555_AAAA, wreg: 7, ready_at: 1});
        ops.push_back('{rd: 1, wr: 0, regw: 1, addr: 32'h0000_0040, data: 32'h0, rdata: 32'hCAFE_F00D, wreg: 3, ready_at: TIMEOUT});
        ops.push_back('{rd: 1, wr: 1, regw: 1, addr: 32'h0000_0024, data: 32'hA5A5_0001, rdata: 32'h0, wreg: 5, ready_at: 2});
        ops.push_back('{rd: 1, wr: 0, regw: 1, addr: 32'h0000_0080, data: 32'h0, rdata: 32'h0BAD_0BAD, wreg: 6, ready_at: TIMEOUT + 1});
        for (int i = 0; i < 24; i++) begin
            int kind;
            kind       = $urandom_range(0, 3);
            op.rd      = (kind == 1) || (kind == 3);
            op.wr      = (kind == 2) || (kind == 3);
            op.regw    = 1'($urandom_range(0, 1));
            op.addr    = $urandom;
            if ($urandom_range(0, 3) != 0) op.addr[1:0] = 2'b00;
            op.data    = $urandom;
            op.rdata   = $urandom;
            op.wreg    = 5'($urandom_range(0, 31));
            op.ready_at = $urandom_range(1, TIMEOUT + 2);
            ops.push_back(op);
        end

        foreach (ops[k]) begin
            op = ops[k];
            e  = model(op);
            run_op(op, cycles, stalls, reqs, wes, addr_seen, wdata_seen, finished);
            total_cnt++;
            if (!finished) begin
                $display("FAIL op%0d_done: stall never released within 300 cycles", k);
            end else pass_cnt++;
            total_cnt++;
            if ({cycles, stalls, reqs} !== {e.cycles, e.stalls, e.reqs}) begin
                $display("FAIL op%0d_timing: got cycles=%0d stalls=%0d reqs=%0d want %0d/%0d/%0d",
                         k, cycles, stalls, reqs, e.cycles, e.stalls, e.reqs);
            end else pass_cnt++;
            total_cnt++;
            if (wes !== (op.wr ? e.reqs : 0)) begin
                $display("FAIL op%0d_we: got %0d write-request cycles want %0d",
                         k, wes, (op.wr ? e.reqs : 0));
            end else pass_cnt++;
            if (e.reqs > 0) begin
                total_cnt++;
                if ({addr_seen, wdata_seen} !== {op.addr, op.data}) begin
                    $display("FAIL op%0d_port: got addr=%h wdata=%h want %h/%h",
                             k, addr_seen, wdata_seen, op.addr, op.data);
                end else pass_cnt++;
            end
            total_cnt++;
            if ({wb_valid, wb_reg_write, addr_err, bus_err, wb_write_reg} !==
                {1'b1, e.regw, e.aerr, e.berr, op.wreg}) begin
                $display("FAIL op%0d_wb: got valid/regw/aerr/berr=%b%b%b%b reg=%0d want 1%b%b%b reg=%0d",
                         k, wb_valid, wb_reg_write, addr_err, bus_err, wb_write_reg,
                         e.regw, e.aerr, e.berr, op.wreg);
            end else pass_cnt++;
            if (e.chk_m2r) begin
                total_cnt++;
                if (wb_mem_to_reg !== e.m2r) begin
                    $display("FAIL op%0d_m2r: got %b want %b", k, wb_mem_to_reg, e.m2r);
                end else pass_cnt++;
            end
            if (e.chk_rdata) begin
                total_cnt++;
                if (wb_read_data !== op.rdata) begin
                    $display("FAIL op%0d_rdata: got %h want %h", k, wb_read_data, op.rdata);
                end else pass_cnt++;
            end
            if (e.chk_result) begin
                total_cnt++;
                if (wb_result !== op.addr) begin
                    $display("FAIL op%0d_result: got %h want %h", k, wb_result, op.addr);
                end else pass_cnt++;
            end
            // Error pulses last exactly one cycle; nothing new is issued here.
            @(posedge clk);
            #1;
            total_cnt++;
            if ({addr_err, bus_err, wb_valid, dmem_req} !== 4'b0000) begin
                $display("FAIL op%0d_idle: got aerr/berr/valid/req=%b%b%b%b want 0000",
                         k, addr_err, bus_err, wb_valid, dmem_req);
            end else pass_cnt++;
        end
    endtask

    // Timed-out load followed by a late ready that must change nothing.
    task automatic test_late_ready();
        op_t  op;
        int   cycles, stalls, reqs, wes;
        logic [31:0] addr_seen, wdata_seen;
        logic finished;
        op = '{rd: 1, wr: 0, regw: 1, addr: 32'h0000_0100, data: 32'h0,
               rdata: 32'h7777_7777, wreg: 12, ready_at: 1000};
        run_op(op, cycles, stalls, reqs, wes, addr_seen, wdata_seen, finished);
        total_cnt++;
        if ({finished, reqs, bus_err, wb_reg_write} !== {1'b1, TIMEOUT, 1'b1, 1'b0}) begin
            $display("FAIL late_timeout: got done=%b reqs=%0d berr=%b regw=%b want 1/%0d/1/0",
                     finished, reqs, bus_err, wb_reg_write, TIMEOUT);
        end else pass_cnt++;
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if ({dmem_req, wb_valid, wb_reg_write, bus_err, stall} !== 5'b0) begin
                $display("FAIL late_ready%0d: got req/valid/regw/berr/stall=%b want 00000",
                         i, {dmem_req, wb_valid, wb_reg_write, bus_err, stall});
            end else pass_cnt++;
        end
        dmem_ready = 1'b0;
    endtask

    // Continuously presented loads answered immediately: one op every two
    // cycles, the request dropping for one cycle in between.
    task automatic test_back_to_back();
        logic exp_req, exp_stall, exp_valid;
        in_valid      = 1'b1;
        in_mem_read   = 1'b1;
        in_mem_write  = 1'b0;
        in_reg_write  = 1'b1;
        in_alu_result = 32'h0000_0200;
        in_write_reg  = 5'd17;
        dmem_rdata    = 32'h0102_0304;
        for (int i = 0; i < 6; i++) begin
            exp_req   = (i % 2 == 1);
            exp_stall = (i % 2 == 0);
            exp_valid = (i >= 2) && (i % 2 == 0);
            @(negedge clk);
            dmem_ready = dmem_req;
            #1;
            total_cnt++;
            if ({dmem_req, stall, wb_valid} !== {exp_req, exp_stall, exp_valid}) begin
                $display("FAIL b2b_c%0d: got req/stall/valid=%b%b%b want %b%b%b",
                         i, dmem_req, stall, wb_valid, exp_req, exp_stall, exp_valid);
            end else pass_cnt++;
            @(posedge clk);
            #1;
        end
        in_valid    = 1'b0;
        in_mem_read = 1'b0;
        dmem_ready  = 1'b0;
        total_cnt++;
        if ({wb_valid, wb_mem_to_reg, wb_read_data} !== {1'b1, 1'b1, 32'h0102_0304}) begin
            $display("FAIL b2b_wb: got valid=%b m2r=%b rdata=%h want 1/1/01020304",
                     wb_valid, wb_mem_to_reg, wb_read_data);
        end else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_access();
        in_valid      = 1'b1;
        in_mem_read   = 1'b1;
        in_mem_write  = 1'b0;
        in_reg_write  = 1'b1;
        in_alu_result = 32'h0000_0300;
        in_write_reg  = 5'd21;
        dmem_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({dmem_req, stall} !== 2'b11) begin
            $display("FAIL rst_pre: got req/stall=%b%b want 11", dmem_req, stall);
        end else pass_cnt++;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if ({dmem_req, wb_valid, wb_reg_write, addr_err, bus_err} !== 5'b0) begin
                $display("FAIL rst_hold%0d: got req/valid/regw/aerr/berr=%b want 00000",
                         i, {dmem_req, wb_valid, wb_reg_write, addr_err, bus_err});
            end else pass_cnt++;
        end
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_mem_read = 1'b0;
        // Ready after reset must not complete anything: the FSM is back in IDLE.
        dmem_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if ({dmem_req, wb_valid, wb_reg_write, addr_err, bus_err} !== 5'b0) begin
                $display("FAIL rst_after%0d: got req/valid/regw/aerr/berr=%b want 00000",
                         i, {dmem_req, wb_valid, wb_reg_write, addr_err, bus_err});
            end else pass_cnt++;
        end
        dmem_ready = 1'b0;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_alu_result = '0;
        in_write_data = '0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_reg_write  = 1'b0;
        in_write_reg  = '0;
        dmem_ready    = 1'b0;
        dmem_rdata    = '0;
        test_reset();
        test_ops();
        test_late_ready();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
